// File: rtl/dpram_fifo_ctrl.sv
// Purpose: valid/ready FIFO controller around an external dual-port RAM (port a writes, port b reads).
// Latency: a word accepted at edge E is presented on m_valid/m_data after edge E+2 (empty controller).
// Backpressure: s_ready drops when DEPTH words are held; reads stop when the 2-entry output buffer is committed.
module dpram_fifo_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W:0]   level,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] data_i_a,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] data_o_b
);

  // Full count is exactly DEPTH = 2^ADDR_W, i.e. only the MSB of the count set.
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   rd_avail;   // written to RAM, read not yet issued
  logic [ADDR_W:0]   level_q;    // RAM + in-flight + output buffer
  logic              inflight;   // read issued last cycle; its data is on data_o_b now
  logic [1:0]        obuf_cnt;
  logic [DATA_W-1:0] obuf0;      // oldest entry, drives m_data
  logic [DATA_W-1:0] obuf1;

  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [1:0] occ;
  logic [1:0] cnt_after_pop;

  // Handshake decode; clr and reset mask every RAM strobe and every transfer.
  always_comb begin
    s_ready       = (level_q < FULL_CNT);
    m_valid       = (obuf_cnt != 2'd0);
    push          = rst_n && !clr && s_valid && s_ready;
    pop           = rst_n && !clr && m_valid && m_ready;
    occ           = obuf_cnt + {1'b0, inflight};
    cnt_after_pop = obuf_cnt - {1'b0, pop};
    // A read may only be issued if its data is guaranteed a buffer slot when it lands.
    rd_issue      = rst_n && !clr && (rd_avail != '0) &&
                    ((occ < 2'd2) || ((occ == 2'd2) && pop));
  end

  // RAM port drive and status outputs.
  always_comb begin
    ena      = push;
    wea      = push;
    addra    = wptr;
    data_i_a = push ? s_data : '0;
    enb      = rd_issue;
    web      = 1'b0;
    addrb    = rptr;
    m_data   = obuf0;
    level    = level_q;
  end

  // Write pointer advances once per accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (clr) begin
      wptr <= '0;
    end else if (push) begin
      wptr <= wptr + PTR_ONE;
    end
  end

  // Read pointer and in-flight flag follow each issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr     <= '0;
      inflight <= 1'b0;
    end else if (clr) begin
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (rd_issue) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Readable-word count: a push only becomes readable after the edge that writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_avail <= '0;
    end else if (clr) begin
      rd_avail <= '0;
    end else begin
      case ({push, rd_issue})
        2'b10:   rd_avail <= rd_avail + CNT_ONE;
        2'b01:   rd_avail <= rd_avail - CNT_ONE;
        default: rd_avail <= rd_avail;
      endcase
    end
  end

  // Total occupancy seen by the producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else if (clr) begin
      level_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level_q <= level_q + CNT_ONE;
        2'b01:   level_q <= level_q - CNT_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Output buffer: shift on pop, land returning RAM data in the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf_cnt <= 2'd0;
      obuf0    <= '0;
      obuf1    <= '0;
    end else if (clr) begin
      // Any RAM word still returning from an earlier read is dropped here.
      obuf_cnt <= 2'd0;
      obuf0    <= '0;
      obuf1    <= '0;
    end else begin
      obuf_cnt <= cnt_after_pop + {1'b0, inflight};
      if (pop) begin
        obuf0 <= obuf1;
      end
      if (inflight) begin
        if (cnt_after_pop == 2'd0) begin
          obuf0 <= data_o_b;
        end else begin
          obuf1 <= data_o_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Purpose: self-checking bench for dpram_fifo_ctrl with a behavioural dual-port RAM.
// Latency: directed vector table plus multi-cycle sequences for fill, wrap, stall, clr, reset.
// Backpressure: m_ready patterns are driven by the bench; s_ready is observed.
module tb_dpram_fifo_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W:0]   level;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] data_i_a;
  logic              enb;
  logic              web;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] data_o_b;

  int n_checks = 0;
  int n_fail   = 0;

  dpram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ena(ena), .wea(wea), .addra(addra), .data_i_a(data_i_a),
    .enb(enb), .web(web), .addrb(addrb), .data_o_b(data_o_b)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: port a writes, port b registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= data_i_a;
    if (enb) data_o_b <= mem[addrb];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              clr;
    logic              sv;
    logic [DATA_W-1:0] sd;
    logic              mr;
    logic              e_ena;
    logic              e_enb;
    logic [ADDR_W-1:0] e_addra;
    logic [ADDR_W-1:0] e_addrb;
    logic              e_mv;
    logic [DATA_W-1:0] e_md;
    logic [ADDR_W:0]   e_lvl;
  } vec_t;

  vec_t vt [15];

  initial begin
    int pops, i_push, bad, first, last, maxlvl, hold_bad, ob_bad, got;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [3:0]        pat;

    // Cycle-by-cycle expectations from a freshly reset controller.
    //          clr  sv    sd        mr    ena   enb   addra addrb  mv    md         lvl
    vt[0]  = '{1'b0,1'b1,16'hA5A5,1'b1, 1'b1,1'b0,8'd0,8'd0, 1'b0,16'h0000, 9'd0};
    vt[1]  = '{1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b1,8'd1,8'd0, 1'b0,16'h0000, 9'd1};
    vt[2]  = '{1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,8'd1,8'd1, 1'b0,16'h0000, 9'd1};
    vt[3]  = '{1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,8'd1,8'd1, 1'b1,16'hA5A5, 9'd1};
    vt[4]  = '{1'b0,1'b1,16'h0001,1'b0, 1'b1,1'b0,8'd1,8'd1, 1'b0,16'h0000, 9'd0};
    vt[5]  = '{1'b0,1'b1,16'h0002,1'b0, 1'b1,1'b1,8'd2,8'd1, 1'b0,16'h0000, 9'd1};
    vt[6]  = '{1'b0,1'b1,16'h0003,1'b0, 1'b1,1'b1,8'd3,8'd2, 1'b0,16'h0000, 9'd2};
    vt[7]  = '{1'b0,1'b1,16'h0004,1'b0, 1'b1,1'b0,8'd4,8'd3, 1'b1,16'h0001, 9'd3};
    vt[8]  = '{1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'd5,8'd3, 1'b1,16'h0001, 9'd4};
    vt[9]  = '{1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b1,8'd5,8'd3, 1'b1,16'h0001, 9'd4};
    vt[10] = '{1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'd5,8'd4, 1'b1,16'h0002, 9'd3};
    vt[11] = '{1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b1,8'd5,8'd4, 1'b1,16'h0002, 9'd3};
    vt[12] = '{1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,8'd5,8'd5, 1'b1,16'h0003, 9'd2};
    vt[13] = '{1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,8'd5,8'd5, 1'b1,16'h0004, 9'd1};
    vt[14] = '{1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'd5,8'd5, 1'b0,16'h0000, 9'd0};

    // ---------------- reset state, with inputs active ----------------
    rst_n = 1'b0; clr = 1'b0; s_valid = 1'b1; s_data = 16'hFFFF; m_ready = 1'b1;
    #2;
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_wea", 32'(wea), 32'd0);
    check("rst_enb", 32'(enb), 32'd0);
    check("rst_data_i_a", 32'(data_i_a), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    tick(); tick();
    #1 rst_n = 1'b1; s_valid = 1'b0; s_data = '0;
    tick();

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 15; i++) begin
      clr = vt[i].clr; s_valid = vt[i].sv; s_data = vt[i].sd; m_ready = vt[i].mr;
      #4;
      check($sformatf("vec%0d_ena", i),   32'(ena),   32'(vt[i].e_ena));
      check($sformatf("vec%0d_wea", i),   32'(wea),   32'(vt[i].e_ena));
      check($sformatf("vec%0d_enb", i),   32'(enb),   32'(vt[i].e_enb));
      check($sformatf("vec%0d_addra", i), 32'(addra), 32'(vt[i].e_addra));
      check($sformatf("vec%0d_addrb", i), 32'(addrb), 32'(vt[i].e_addrb));
      check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vt[i].e_mv));
      if (vt[i].e_mv) check($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vt[i].e_md));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].e_lvl));
      tick();
    end

    // ---------------- fill to DEPTH with m_ready low ----------------
    m_ready = 1'b0; bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      #4;
      if (!s_ready) bad++;
      tick();
    end
    check("fill_s_ready_during_fill", 32'(bad), 32'd0);
    s_data = 16'hDEAD;
    #4;
    check("fill_level_full", 32'(level), 32'(DEPTH));
    check("fill_s_ready_low", 32'(s_ready), 32'd0);
    check("fill_257th_not_written", 32'(ena), 32'd0);
    tick();
    #4;
    check("fill_level_held", 32'(level), 32'(DEPTH));
    tick();
    s_valid = 1'b0; m_ready = 1'b1; pops = 0; bad = 0;
    for (int cyc = 0; cyc < 400 && pops < DEPTH; cyc++) begin
      #4;
      if (m_valid) begin
        if (m_data !== 16'(pops)) bad++;
        pops++;
      end
      tick();
    end
    check("fill_drain_count", 32'(pops), 32'(DEPTH));
    check("fill_drain_order", 32'(bad), 32'd0);
    #4;
    check("fill_drain_level", 32'(level), 32'd0);
    tick();

    // ---------------- streaming across pointer wrap ----------------
    pops = 0; i_push = 0; bad = 0; first = -1; last = -1; maxlvl = 0;
    for (int cyc = 0; cyc < 1100 && pops < 1000; cyc++) begin
      s_valid = (i_push < 1000); s_data = 16'(i_push + 1000); m_ready = 1'b1;
      #4;
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (s_valid && s_ready) i_push++;
      if (m_valid) begin
        if (m_data !== 16'(pops + 1000)) bad++;
        if (first < 0) first = cyc;
        last = cyc;
        pops++;
      end
      tick();
    end
    s_valid = 1'b0;
    check("stream_count", 32'(pops), 32'd1000);
    check("stream_order", 32'(bad), 32'd0);
    check("stream_one_per_cycle", 32'(last - first + 1), 32'd1000);
    check("stream_level_le3", 32'(maxlvl <= 3), 32'd1);

    // ---------------- backpressure pattern 1,0,0,1 ----------------
    pat = 4'b1001; pops = 0; i_push = 0; bad = 0; hold_bad = 0; ob_bad = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 2000 && pops < 200; cyc++) begin
      s_valid = (i_push < 200); s_data = 16'(16'h4000 + i_push); m_ready = pat[cyc % 4];
      #4;
      if (prev_stall && (!m_valid || m_data !== prev_data)) hold_bad++;
      if (dut.obuf_cnt > 2'd2) ob_bad++;
      if (s_valid && s_ready) i_push++;
      if (m_valid && m_ready) begin
        if (m_data !== 16'(16'h4000 + pops)) bad++;
        pops++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
    end
    s_valid = 1'b0;
    check("bp_count", 32'(pops), 32'd200);
    check("bp_order", 32'(bad), 32'd0);
    check("bp_hold_while_stalled", 32'(hold_bad), 32'd0);
    check("bp_obuf_le2", 32'(ob_bad), 32'd0);
    tick(); tick(); tick();

    // ---------------- clr with a read in flight ----------------
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 16'h7777; tick();
    s_data = 16'h8888; tick();
    s_data = 16'h9999; tick();
    clr = 1'b1; s_data = 16'h5555; m_ready = 1'b1;
    #4;
    check("clr_ena_masked", 32'(ena), 32'd0);
    check("clr_enb_masked", 32'(enb), 32'd0);
    tick();
    clr = 1'b0; s_valid = 1'b0;
    #4;
    check("clr_level_zero", 32'(level), 32'd0);
    check("clr_m_valid_zero", 32'(m_valid), 32'd0);
    tick();
    #4;
    check("clr_inflight_dropped", 32'(m_valid), 32'd0);
    tick();
    s_valid = 1'b1; s_data = 16'h1234;
    tick();
    s_valid = 1'b0; got = 0;
    for (int cyc = 0; cyc < 8 && got == 0; cyc++) begin
      #4;
      if (m_valid) begin
        got = 1;
        check("clr_first_word", 32'(m_data), 32'h1234);
      end
      tick();
    end
    check("clr_word_emerged", 32'(got), 32'd1);
    tick();

    // ---------------- reset mid-stream ----------------
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 16'(16'h0600 + i); tick();
    end
    s_valid = 1'b0;
    #4;
    check("rst_mid_level10", 32'(level), 32'd10);
    @(posedge clk); #2;
    s_valid = 1'b1; s_data = 16'hCAFE; m_ready = 1'b1; rst_n = 1'b0;
    #1;
    check("rstmid_level", 32'(level), 32'd0);
    check("rstmid_m_valid", 32'(m_valid), 32'd0);
    check("rstmid_m_data", 32'(m_data), 32'd0);
    check("rstmid_s_ready", 32'(s_ready), 32'd1);
    check("rstmid_strobes", 32'({ena, wea, enb, web}), 32'd0);
    check("rstmid_addr", 32'({addra, addrb}), 32'd0);
    check("rstmid_data_i_a", 32'(data_i_a), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; s_valid = 1'b0;
    tick();
    #4;
    check("rstmid_level_after", 32'(level), 32'd0);
    check("rstmid_m_valid_after", 32'(m_valid), 32'd0);
    tick();
    // Push at edge E; word must appear after E+2, not earlier.
    s_valid = 1'b1; s_data = 16'hBEEF; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    #4;
    check("lat_after_e1", 32'(m_valid), 32'd0);
    @(posedge clk); #5;
    check("lat_after_e2", 32'(m_valid), 32'd0);
    @(posedge clk); #5;
    check("lat_after_e3_valid", 32'(m_valid), 32'd1);
    check("lat_after_e3_data", 32'(m_data), 32'hBEEF);
    @(posedge clk); #5;
    check("lat_level_back_to_zero", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width; depth DEPTH = 2^ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 16, RAM and stream data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous flush.
REQ-006 SHALL have port s_valid  input  1  write-side word offered.
REQ-007 SHALL have port s_ready  output  1  write side can accept.
REQ-008 SHALL have port s_data  input  DATA_W  write-side word.
REQ-009 SHALL have port m_valid  output  1  read-side word available.
REQ-010 SHALL have port m_ready  input  1  read side consumes.
REQ-011 SHALL have port m_data  output  DATA_W  read-side word.
REQ-012 SHALL have port level  output  ADDR_W+1  words held, counting RAM, in-flight and output buffer.
REQ-013 SHALL have port ena, wea  output  1 each  RAM channel-a enable and write enable.
REQ-014 SHALL have port addra  output  ADDR_W  RAM channel-a address.
REQ-015 SHALL have port data_i_a  output  DATA_W  RAM channel-a write data.
REQ-016 SHALL have port enb, web  output  1 each  RAM channel-b enable and write enable; web tied 0.
REQ-017 SHALL have port addrb  output  ADDR_W  RAM channel-b address.
REQ-018 SHALL have port data_o_b  input  DATA_W  RAM channel-b registered read data, valid one cycle after enb.

Function
REQ-019 SHALL accept a push when s_valid && s_ready, driving ena=wea=1, addra=wptr, data_i_a=s_data combinationally in that cycle, and increment wptr modulo DEPTH.
REQ-020 SHALL drive s_ready = (level < DEPTH); ena and wea SHALL be 0 in any cycle without a push.
REQ-021 SHALL count a pushed word as readable from the RAM (rd_avail) only after the edge that writes it, so that channel b never reads an address being written in the same cycle.
REQ-022 SHALL issue a read (enb=1, addrb=rptr, rptr+1 mod DEPTH) when rd_avail>0 and (obuf_cnt + inflight) < 2, or when that sum is 2 and a pop occurs in the same cycle.
REQ-023 SHALL hold a 2-entry output buffer that captures data_o_b on the edge after each issued read; m_data SHALL be the oldest entry and m_valid = (obuf_cnt > 0).
REQ-024 SHALL pop on m_valid && m_ready; m_data and m_valid SHALL stay stable while m_valid && !m_ready.
REQ-025 SHALL sustain one push and one pop per cycle indefinitely when neither side stalls.
REQ-026 SHALL make the first word visible at m_valid two rising edges after the edge that accepted it (empty controller, m_ready don't-care).
REQ-027 SHALL update level by +1 on a push, -1 on a pop, unchanged on both or neither; level SHALL never exceed DEPTH.
REQ-028 SHALL handle wrap-around of wptr and rptr from DEPTH-1 to 0 with no lost or duplicated word.
REQ-029 SHALL, on clr=1, zero wptr, rptr, rd_avail, level, obuf_cnt and inflight at that edge; a push or pop in that cycle SHALL be ignored, ena, wea and enb SHALL be 0 in that cycle, and RAM data from an earlier in-flight read SHALL be discarded.
REQ-030 SHALL deliver words in exact push order.

Reset
REQ-031 SHALL, while rst_n=0, force wptr=rptr=0, level=0, obuf_cnt=0, inflight=0, m_valid=0, s_ready=1, m_data=0, ena=wea=enb=web=0, addra=addrb=0, data_i_a=0, independent of clk.
REQ-032 SHALL, on reset asserted mid-transfer, discard all held words; after release the first push SHALL behave as on an empty controller.

Verification
REQ-033 Single word: push 0xA5A5 at edge E, m_ready=1 -> m_valid=1 after E+2, m_data=0xA5A5, level returns to 0 after the pop.
REQ-034 Fill: push 256 words 0..255 with m_ready=0 -> s_ready=0 with level=256; the 257th offer is not accepted; drain yields 0..255 in order.
REQ-035 Streaming wrap: 1000 back-to-back pushes with m_ready=1 -> one pop per cycle in steady state; output is the incrementing sequence across pointer wrap; level stays at or below 3.
REQ-036 Backpressure: toggle m_ready in the pattern 1,0,0,1 during streaming -> m_data is held while stalled; no loss or duplication; obuf_cnt stays at or below 2.
REQ-037 clr with a read in flight -> next cycle level=0 and m_valid=0; a subsequent push of 0x1234 emerges first.
REQ-038 rst_n pulsed low mid-stream with level=10 -> outputs take REQ-031 values immediately; level=0 after release.
